// File: rtl/alu_nibble_seq_if.sv
// Bundles the request/response and ALU-facing signals of the nibble-serial sequencer.
// slave = sequencer side, master = requester plus the attached 4-bit ALU.
interface alu_nibble_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   op_s;
    logic         op_m;
    logic         op_cin_n;

    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         result_cout_n;

    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [3:0]   alu_s;
    logic         alu_m;
    logic         alu_cin_re;
    logic [3:0]   alu_y;
    logic         alu_cout_re;

    modport slave (
        input  start, op_a, op_b, op_s, op_m, op_cin_n,
        output busy, done, result, result_cout_n,
        output alu_a, alu_b, alu_s, alu_m, alu_cin_re,
        input  alu_y, alu_cout_re
    );

    modport master (
        output start, op_a, op_b, op_s, op_m, op_cin_n,
        input  busy, done, result, result_cout_n,
        input  alu_a, alu_b, alu_s, alu_m, alu_cin_re,
        output alu_y, alu_cout_re
    );
endinterface

// File: rtl/alu_nibble_seq.sv
// Nibble-serial sequencer around a 4-bit 74181-style ALU, LSB nibble first, carry rippled via a register.
// Latency: done pulses NIBBLES cycles after the accepting edge, for one cycle.
// Backpressure: start is taken only in IDLE/DONE; start during RUN is dropped, never queued.
module alu_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    alu_nibble_seq_if.slave  bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    logic [1:0]       state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [3:0]       s_q;
    logic             m_q;
    logic [W-1:0]     result_q;
    logic             cout_n_q;
    logic [IDX_W+1:0] nib_base;
    logic             accept;

    assign nib_base = {idx_q, 2'b00};
    assign accept   = (state_q != ST_RUN) && bus.start;

    assign bus.busy          = (state_q == ST_RUN);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.result        = result_q;
    assign bus.result_cout_n = cout_n_q;

    // Outside RUN the ALU sees a quiescent logic-mode, carry-inactive input set.
    always_comb begin
        bus.alu_a      = 4'h0;
        bus.alu_b      = 4'h0;
        bus.alu_s      = 4'h0;
        bus.alu_m      = 1'b1;
        bus.alu_cin_re = 1'b1;
        if (state_q == ST_RUN) begin
            bus.alu_a      = a_q[nib_base +: 4];
            bus.alu_b      = b_q[nib_base +: 4];
            bus.alu_s      = s_q;
            bus.alu_m      = m_q;
            bus.alu_cin_re = m_q | carry_q;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= 4'h0;
            m_q      <= 1'b1;
            result_q <= '0;
            cout_n_q <= 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    result_q[nib_base +: 4] <= bus.alu_y;
                    carry_q                 <= bus.alu_cout_re;
                    if (idx_q == LAST_IDX) begin
                        // Logic mode has no meaningful carry; report it as inactive.
                        cout_n_q <= m_q | bus.alu_cout_re;
                        idx_q    <= '0;
                        state_q  <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        a_q     <= bus.op_a;
                        b_q     <= bus.op_b;
                        s_q     <= bus.op_s;
                        m_q     <= bus.op_m;
                        carry_q <= bus.op_cin_n;
                        idx_q   <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Nibble-serial sequencer wrapped around the 4-bit 74181-style ALU (`alu_4bit`).
- Accepts one 4*NIBBLES-bit operation per start pulse.
- Feeds the ALU one nibble per cycle, LSB nibble first, and ripples the active-low carry through a register between nibbles.
- Collects the nibble results into a wide result word plus final carry.
- Sits directly upstream of `alu_4bit` (drives a/b/s/m/cin_re) and directly downstream of it (consumes y/cout_re).

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when not busy.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- op_s  in  4  ALU function select.
- op_m  in  1  mode: 1 = logic, 0 = arithmetic.
- op_cin_n  in  1  active-low carry-in for nibble 0.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  W  assembled result.
- result_cout_n  out  1  final active-low carry-out.
- alu_a  out  4  to ALU a.
- alu_b  out  4  to ALU b.
- alu_s  out  4  to ALU s.
- alu_m  out  1  to ALU m.
- alu_cin_re  out  1  to ALU cin_re.
- alu_y  in  4  from ALU y.
- alu_cout_re  in  1  from ALU cout_re.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0, result_cout_n=1.
  - Index=0, carry register=1.
  - alu_a=0, alu_b=0, alu_s=0, alu_m=1, alu_cin_re=1.
  - Reset mid-operation aborts immediately; no done is produced.
- State machine:
  - IDLE: busy=0. On start=1 at edge E0, latch op_a/op_b/op_s/op_m, load carry register with op_cin_n, set index=0, go to RUN.
  - RUN: busy=1.
    - ALU path is combinational; each cycle the block drives alu_a=A[4*idx+:4], alu_b=B[4*idx+:4], alu_s/alu_m from the latches.
    - alu_cin_re = carry register when m=0, forced 1 when m=1.
    - At each edge: result[4*idx+:4] <= alu_y; carry register <= alu_cout_re; idx increments.
    - When idx==NIBBLES-1 at the edge: result_cout_n <= alu_cout_re (forced 1 if m=1), done <= 1, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start=1 in DONE is accepted exactly as in IDLE.
- Latency: start at E0; nibbles captured at E1..E_NIBBLES; done is high between E_NIBBLES and E_NIBBLES+1. For NIBBLES=4, done is visible 4 cycles after the start edge.
- result and result_cout_n:
  - Update only nibble-by-nibble during RUN.
  - Hold their final value until the next accepted start.
  - Intermediate nibbles are visible while busy=1 and are not valid.
- start while busy=1 (RUN) is ignored and not queued.
- Operand inputs are sampled only at the accepting edge; later changes have no effect.
- Logic mode: carry is not propagated; result_cout_n=1.
- Carry wrap: overflow past the top nibble appears only on result_cout_n; the result wraps modulo 2^W.

Test Plan:
- Add without carry:
  - Stimulus: NIBBLES=4, op_a=0x1234, op_b=0x0FFF, op_s=1001, op_m=0, op_cin_n=1, start pulse.
  - Required: done 4 cycles later; result=0x2233; result_cout_n=1.
- Add with overflow:
  - Stimulus: op_a=0xFFFF, op_b=0x0001, op_s=1001, op_m=0, op_cin_n=1.
  - Required: result=0x0000; result_cout_n=0; carry visibly ripples through all 4 nibbles (alu_cin_re=0 on nibbles 1..3).
- Carry-in only:
  - Stimulus: op_a=0x00FF, op_b=0x0000, op_s=1001, op_m=0, op_cin_n=0.
  - Required: result=0x0100; result_cout_n=1.
- Logic XOR:
  - Stimulus: op_a=0xA5A5, op_b=0x0FF0, op_s=0110, op_m=1, op_cin_n=0.
  - Required: result=0xAA55; alu_cin_re=1 in all RUN cycles; result_cout_n=1.
- Start while busy, then back-to-back:
  - Stimulus: start pulse again on the 2nd RUN cycle with different operands.
  - Required: ignored; first result unchanged.
  - Stimulus: start asserted in the DONE cycle.
  - Required: accepted; busy high the next cycle; second done exactly 4 cycles later.
- Reset mid-operation:
  - Stimulus: rst_n=0 asynchronously during the 3rd RUN cycle.
  - Required: busy=0, done=0, result=0, result_cout_n=1 immediately; no done pulse after release; next start completes normally.
